// File: rtl/lfsr_checker_4bit_pkg.sv
// Shared definitions for the 4-bit LFSR pattern checker: word width, taps,
// lockup word and checker state encoding.
package lfsr_checker_4bit_pkg;

  localparam int unsigned LFSR_W = 4;
  // Feedback taps for x^4+x^3+1 with the newest bit entering at the MSB.
  localparam int unsigned TAP_HI = 1;
  localparam int unsigned TAP_LO = 0;
  localparam logic [LFSR_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_checker_4bit_next.sv
// Combinational next-word function of the 4-bit generator; the lockup word
// 0000 maps to itself.
module lfsr_checker_4bit_next
  import lfsr_checker_4bit_pkg::*;
(
  input  logic [LFSR_W-1:0] x_i,
  output logic [LFSR_W-1:0] y_o
);

  assign y_o = {x_i[TAP_HI] ^ x_i[TAP_LO], x_i[LFSR_W-1:1]};

endmodule

// File: rtl/lfsr_checker_4bit.sv
// Receive-side checker for the 4-bit LFSR pattern: self-synchronises, then
// flywheels a local model. Optional LFSR_CHECKER_ZERO_DETECT_EN adds stuck_zero.
module lfsr_checker_4bit
  import lfsr_checker_4bit_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        data_in,
  output logic              locked,
  output logic              error,
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
  output logic              stuck_zero,
`endif
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);

  state_e              state_q;
  logic [LFSR_W-1:0]   prev_q, exp_q;
  logic [MW-1:0]       match_cnt_q;
  logic [LW-1:0]       miss_cnt_q;
  logic                locked_q, error_q;
  logic [ERR_W-1:0]    err_cnt_q;
  logic [LFSR_W-1:0]   f_prev, f_exp, f_din;
  logic                sync_hit, lock_miss, zero_hold;

  lfsr_checker_4bit_next u_next_prev (.x_i(prev_q),  .y_o(f_prev));
  lfsr_checker_4bit_next u_next_exp  (.x_i(exp_q),   .y_o(f_exp));
  lfsr_checker_4bit_next u_next_din  (.x_i(data_in), .y_o(f_din));

  assign sync_hit  = (data_in == f_prev) && (data_in != ZERO_WORD);
  assign lock_miss = (data_in != exp_q);

`ifdef LFSR_CHECKER_ZERO_DETECT_EN
  logic [1:0] zrun_q;
  logic       stuck_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      zrun_q  <= '0;
      stuck_q <= 1'b0;
    end else if (en) begin
      if (data_in == ZERO_WORD) begin
        if (zrun_q == 2'd3) stuck_q <= 1'b1;
        else                zrun_q  <= zrun_q + 2'd1;
      end else begin
        zrun_q  <= '0;
        stuck_q <= 1'b0;
      end
    end
  end

  // A generator lockup already flagged is not double-reported as errors.
  assign zero_hold  = stuck_q;
  assign stuck_zero = stuck_q;
`else
  assign zero_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else if (!en) begin
      error_q <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          prev_q      <= data_in;
          match_cnt_q <= '0;
          state_q     <= ST_SYNC;
        end
        ST_SYNC: begin
          prev_q <= data_in;
          if (sync_hit) begin
            if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
              state_q     <= ST_LOCKED;
              locked_q    <= 1'b1;
              exp_q       <= f_din;
              miss_cnt_q  <= '0;
              match_cnt_q <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + MW'(1);
            end
          end else begin
            match_cnt_q <= '0;
          end
        end
        ST_LOCKED: begin
          exp_q <= f_exp;
          if (lock_miss) begin
            if (!zero_hold) begin
              error_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
            if (miss_cnt_q == LW'(LOSS_CNT - 1)) begin
              state_q     <= ST_SYNC;
              locked_q    <= 1'b0;
              match_cnt_q <= '0;
              miss_cnt_q  <= '0;
              prev_q      <= data_in;
            end else begin
              miss_cnt_q <= miss_cnt_q + LW'(1);
            end
          end else begin
            miss_cnt_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker_4bit.sv
// Directed bench for lfsr_checker_4bit: default instance plus an ERR_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_lfsr_checker_4bit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  data_in = '0;
  logic        locked1, error1, locked2, error2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
  logic        sz1, sz2;
`endif

  int errors = 0;
  int checks = 0;
  int ec1 = 0;
  int ec2 = 0;

  // Generator output sequence starting from 0001, hand-derived.
  logic [3:0] seq [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                           4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3};

  always #5 clk = ~clk;

  lfsr_checker_4bit #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut1 (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in),
    .locked(locked1), .error(error1),
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
    .stuck_zero(sz1),
`endif
    .err_count(cnt1)
  );

  lfsr_checker_4bit #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in),
    .locked(locked2), .error(error2),
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
    .stuck_zero(sz2),
`endif
    .err_count(cnt2)
  );

  task automatic step(input logic e, input logic [3:0] d);
    en = e;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input logic l, input logic e);
    chk({tag, ".locked"},  {31'd0, locked1}, {31'd0, l});
    chk({tag, ".error"},   {31'd0, error1},  {31'd0, e});
    chk({tag, ".cnt"},     {16'd0, cnt1},    ec1);
    chk({tag, ".locked2"}, {31'd0, locked2}, {31'd0, l});
    chk({tag, ".error2"},  {31'd0, error2},  {31'd0, e});
    chk({tag, ".cnt2"},    {30'd0, cnt2},    ec2);
  endtask

  task automatic bump();
    ec1++;
    if (ec2 < 3) ec2++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    // Reset overrides en with random data.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'($urandom_range(15)));
      chk_all("reset", 1'b0, 1'b0);
    end
    reset = 1'b0;
    step(1'b0, 4'h5);
    chk_all("post_reset", 1'b0, 1'b0);

    // Acquire lock: IDLE sample then four matches.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i]);
      chk_all("acquire", 1'b0, 1'b0);
    end
    step(1'b1, seq[4]);
    chk_all("locked_rise", 1'b1, 1'b0);

    // Flywheel through the correct sequence up to the 0010 slot.
    for (int i = 5; i < 15; i++) step(1'b1, seq[i]);
    for (int i = 0; i < 3; i++) step(1'b1, seq[i]);
    chk_all("flywheel", 1'b1, 1'b0);
    step(1'b1, 4'hF);
    bump();
    chk_all("single_err", 1'b1, 1'b1);
    step(1'b0, 4'h0);
    chk_all("en_gap", 1'b1, 1'b0);
    for (int i = 4; i < 7; i++) begin
      step(1'b1, seq[i]);
      chk_all("resume", 1'b1, 1'b0);
    end

    // Three consecutive corrupt words drop lock.
    step(1'b1, ~seq[7]);  bump(); chk_all("loss1", 1'b1, 1'b1);
    step(1'b1, ~seq[8]);  bump(); chk_all("loss2", 1'b1, 1'b1);
    step(1'b1, ~seq[9]);  bump(); chk_all("loss3", 1'b0, 1'b1);

    // Relock: first word mismatches f(prev), next four match.
    for (int i = 10; i < 14; i++) begin
      step(1'b1, seq[i]);
      chk_all("resync", 1'b0, 1'b0);
    end
    step(1'b1, seq[14]);
    chk_all("relock", 1'b1, 1'b0);

    // Alternate corrupt/correct: counters climb, ERR_W=2 copy saturates.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        step(1'b1, ~seq[i]);
        bump();
        chk_all("alt_bad", 1'b1, 1'b1);
      end else begin
        step(1'b1, seq[i]);
        chk_all("alt_good", 1'b1, 1'b0);
      end
    end
    chk("sat_cnt2", {30'd0, cnt2}, 32'd3);

    // Mid-stream reset.
    reset = 1'b1;
    step(1'b1, seq[10]);
    ec1 = 0;
    ec2 = 0;
    chk_all("mid_reset", 1'b0, 1'b0);
    reset = 1'b0;

    // All-zero stream never locks.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'h0);
      chk_all("zeros", 1'b0, 1'b0);
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
      chk("stuck_zero", {31'd0, sz1}, (i >= 3) ? 32'd1 : 32'd0);
`endif
    end
    step(1'b1, 4'h1);
    chk_all("zeros_end", 1'b0, 1'b0);
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
    chk("stuck_clear", {31'd0, sz1}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
